brainfuck_code_loader: RTL

- Writer side of the brainfuck core's code memory.
- Accepts a byte stream over a valid/ready handshake and keeps only the eight brainfuck opcode characters.
- Writes those opcodes sequentially into the code RAM that brainfuckCore fetches from via addr_code/code_out, then appends a 0x00 halt terminator.
- Holds the core disabled while loading and releases it once the program image is complete.

---
 rtl/brainfuck_code_loader.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/brainfuck_code_loader.sv
// Purpose: writer side of the brainfuck code RAM; filters a byte stream down to opcodes,
//          writes them sequentially, appends a 0x00 halt terminator, then releases the core.
// Latency: an accepted opcode reaches the write port 1 cycle after its handshake; core_enable
//          rises 2 cycles after the 0x00 handshake, so the terminator is committed first.
// Backpressure: i_in_ready is high for the whole LOAD state (one byte per cycle), low otherwise.
//
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_load_start              one-cycle request to start a new load (honoured in IDLE and RUN)
//   i_in_valid/i_in_data      byte stream in, o_in_ready accepts
//   o_code_addr/_data/_we     registered code RAM write port
//   o_core_enable             core may run
//   o_busy                    high in LOAD or TERM
//   o_overflow                sticky: opcodes dropped because memory was full
//   o_loaded_len              opcode count of the last completed load (terminator excluded)
module brainfuck_code_loader #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_load_start,
    input  logic                  i_in_valid,
    input  logic [DATA_WIDTH-1:0] i_in_data,
    output logic                  o_in_ready,
    output logic [ADDR_WIDTH-1:0] o_code_addr,
    output logic [DATA_WIDTH-1:0] o_code_data,
    output logic                  o_code_we,
    output logic                  o_core_enable,
    output logic                  o_busy,
    output logic                  o_overflow,
    output logic [ADDR_WIDTH:0]   o_loaded_len
);

    // The top address is reserved for the terminator, so opcodes stop one short of it.
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_TERM,
        S_RUN
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic                  r_in_ready;
    logic [ADDR_WIDTH-1:0] r_code_addr;
    logic [DATA_WIDTH-1:0] r_code_data;
    logic                  r_code_we;
    logic                  r_core_enable;
    logic                  r_busy;
    logic                  r_overflow;
    logic [ADDR_WIDTH:0]   r_loaded_len;

    logic                  w_is_opcode;
    logic                  w_is_nul;
    logic                  w_handshake;

    always_comb begin
        w_is_opcode = 1'b0;
        case (i_in_data)
            DATA_WIDTH'(8'h2B), DATA_WIDTH'(8'h2D),
            DATA_WIDTH'(8'h3C), DATA_WIDTH'(8'h3E),
            DATA_WIDTH'(8'h5B), DATA_WIDTH'(8'h5D),
            DATA_WIDTH'(8'h2E), DATA_WIDTH'(8'h2C): w_is_opcode = 1'b1;
            default:                                w_is_opcode = 1'b0;
        endcase
    end

    assign w_is_nul    = (i_in_data == '0);
    // r_in_ready is high exactly while in LOAD, so this is also the LOAD-state qualifier.
    assign w_handshake = i_in_valid & r_in_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_in_ready    <= 1'b0;
            r_code_addr   <= '0;
            r_code_data   <= '0;
            r_code_we     <= 1'b0;
            r_core_enable <= 1'b0;
            r_busy        <= 1'b0;
            r_overflow    <= 1'b0;
            r_loaded_len  <= '0;
        end else begin
            r_code_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_load_start) begin
                        r_state    <= S_LOAD;
                        r_ptr      <= '0;
                        r_overflow <= 1'b0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (w_handshake) begin
                        if (w_is_nul) begin
                            r_state    <= S_TERM;
                            r_in_ready <= 1'b0;
                        end else if (w_is_opcode) begin
                            if (r_ptr != LAST_ADDR) begin
                                r_code_we   <= 1'b1;
                                r_code_addr <= r_ptr;
                                r_code_data <= i_in_data;
                                r_ptr       <= r_ptr + 1'b1;
                            end else begin
                                r_overflow  <= 1'b1;
                            end
                        end
                    end
                end
                S_TERM: begin
                    r_code_we    <= 1'b1;
                    r_code_addr  <= r_ptr;
                    r_code_data  <= '0;
                    r_loaded_len <= {1'b0, r_ptr};
                    r_busy       <= 1'b0;
                    r_state      <= S_RUN;
                end
                S_RUN: begin
                    if (i_load_start) begin
                        r_state       <= S_LOAD;
                        r_ptr         <= '0;
                        r_overflow    <= 1'b0;
                        r_in_ready    <= 1'b1;
                        r_busy        <= 1'b1;
                        r_core_enable <= 1'b0;
                    end else begin
                        // Rises one cycle into RUN, after the terminator write is on the port.
                        r_core_enable <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_in_ready    = r_in_ready;
    assign o_code_addr   = r_code_addr;
    assign o_code_data   = r_code_data;
    assign o_code_we     = r_code_we;
    assign o_core_enable = r_core_enable;
    assign o_busy        = r_busy;
    assign o_overflow    = r_overflow;
    assign o_loaded_len  = r_loaded_len;

endmodule
